// File: rtl/sar_dac_pkg.sv
// Shared constants and mode encoding for the 8-bit SAR/PWM/delta-sigma DAC driver.
package sar_dac_pkg;

  localparam int unsigned PERIOD = 256;
  localparam int unsigned DW     = 8;

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_DS  = 1'b1
  } mode_e;

endpackage

// File: rtl/sar_dac_tick_gen.sv
// Clock divider: emits a one-cycle tick every DIV enabled clk cycles.
module sar_dac_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_q, div_d;

  always_comb begin
    tick  = ena && (div_q == LAST);
    div_d = div_q;
    if (ena) begin
      div_d = tick ? '0 : div_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/sar_dac8_driver.sv
// 1-bit DAC stream generator: double-buffered sample, 256-tick period,
// PWM or first-order delta-sigma modulation selected per period.
module sar_dac8_driver
  import sar_dac_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          mode,
  input  logic          clr_underrun,
  output logic          dac_out,
  output logic          period_start,
  output logic          underrun
);

  logic          tick;
  logic          wrap;
  logic          accept;
  logic [DW:0]   sum;
  mode_e         mode_in;

  logic [DW-1:0] phase_q, phase_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] active_q, active_d;
  logic [DW-1:0] pending_q, pending_d;
  logic          pending_full_q, pending_full_d;
  mode_e         mode_q, mode_d;
  logic          dac_out_q, dac_out_d;
  logic          period_start_q, period_start_d;
  logic          underrun_q, underrun_d;

  sar_dac_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tick  (tick)
  );

  // Next-state logic for buffer, phase, modulator and status.
  always_comb begin
    mode_in        = mode_e'(mode);
    wrap           = tick && (phase_q == DW'(PERIOD - 1));
    accept         = din_valid && !pending_full_q;
    sum            = {1'b0, acc_q} + {1'b0, active_q};

    phase_d        = phase_q;
    acc_d          = acc_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    mode_d         = mode_q;
    dac_out_d      = dac_out_q;
    period_start_d = wrap;
    underrun_d     = (wrap && !pending_full_q) || (underrun_q && !clr_underrun);

    if (accept) begin
      pending_d      = din;
      pending_full_d = 1'b1;
    end

    if (tick) begin
      phase_d = phase_q + DW'(1);
      if (mode_q == MODE_DS) begin
        dac_out_d = sum[DW];
        acc_d     = sum[DW-1:0];
      end else begin
        dac_out_d = (phase_q < active_q);
      end
    end

    // An empty buffer at the wrap keeps the old sample; a same-edge accept stays pending.
    if (wrap) begin
      mode_d = mode_in;
      if (pending_full_q) begin
        active_d       = pending_q;
        pending_full_d = 1'b0;
      end
      if (mode_in != mode_q) begin
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q        <= '0;
      acc_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      mode_q         <= MODE_PWM;
      dac_out_q      <= 1'b0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      acc_q          <= acc_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      mode_q         <= mode_d;
      dac_out_q      <= dac_out_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
    end
  end

  assign din_ready    = !pending_full_q;
  assign dac_out      = dac_out_q;
  assign period_start = period_start_q;
  assign underrun     = underrun_q;

endmodule
